// File: rtl/store_pkg.sv
// rtl/store_pkg.sv - shared store sizes, FSM states and byte-count helper
package store_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } store_size_e;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        RESP,
        ERR
    } store_state_e;

    // Reserved size reports zero bytes; callers must treat it as an error.
    function automatic logic [2:0] bytes_of(store_size_e sz);
        case (sz)
            SZ_BYTE: bytes_of = 3'd1;
            SZ_HALF: bytes_of = 3'd2;
            SZ_WORD: bytes_of = 3'd4;
            default: bytes_of = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/store_serializer_if.sv
// rtl/store_serializer_if.sv - store request and byte-wide memory port bundle
interface store_serializer_if
    import store_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    store_size_e       req_size;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_data;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_ready;
    logic              done;
    logic              err;

    modport master (
        output req_valid, req_size, req_addr, req_data, mem_ready,
        input  req_ready, mem_we, mem_addr, mem_wdata, done, err
    );

    modport slave (
        input  req_valid, req_size, req_addr, req_data, mem_ready,
        output req_ready, mem_we, mem_addr, mem_wdata, done, err
    );
endinterface

// File: rtl/store_align_chk.sv
// rtl/store_align_chk.sv - alignment/size legality and byte count for a store
module store_align_chk
    import store_pkg::*;
(
    input  store_size_e size,
    input  logic [1:0]  addr,
    output logic        ok,
    output logic [2:0]  nbytes
);
    always_comb begin
        nbytes = bytes_of(size);
        case (size)
            SZ_BYTE: ok = 1'b1;
            SZ_HALF: ok = ~addr[0];
            SZ_WORD: ok = (addr == 2'b00);
            default: ok = 1'b0;
        endcase
    end
endmodule

// File: rtl/store_serializer.sv
// rtl/store_serializer.sv - narrows sb/sh/sw stores into little-endian byte writes
module store_serializer
    import store_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
)(
    input  logic               clk,
    input  logic               rst,
    store_serializer_if.slave  bus
);
    store_state_e      state;
    logic [1:0]        k;
    logic [1:0]        last;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [7:0]        mem_wdata_q;
    logic              done_q;
    logic              err_q;

    logic       ok;
    logic [2:0] nbytes;
    logic [1:0] kn;

    store_align_chk u_chk (
        .size   (bus.req_size),
        .addr   (bus.req_addr[1:0]),
        .ok     (ok),
        .nbytes (nbytes)
    );

    assign kn = k + 2'd1;

    // The next byte's address and data are registered one beat ahead so the
    // memory port is driven purely from flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            k           <= 2'd0;
            last        <= 2'd0;
            addr_q      <= '0;
            data_q      <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 8'h00;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        if (ok) begin
                            state       <= WRITE;
                            k           <= 2'd0;
                            last        <= 2'(nbytes - 3'd1);
                            addr_q      <= bus.req_addr;
                            data_q      <= bus.req_data;
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= bus.req_addr;
                            mem_wdata_q <= bus.req_data[7:0];
                        end else begin
                            state <= ERR;
                            err_q <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (bus.mem_ready) begin
                        if (k == last) begin
                            state    <= RESP;
                            mem_we_q <= 1'b0;
                            done_q   <= 1'b1;
                        end else begin
                            k           <= kn;
                            mem_addr_q  <= addr_q + ADDR_W'(kn);
                            mem_wdata_q <= data_q[{kn, 3'b000} +: 8];
                        end
                    end
                end
                RESP: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                ERR: begin
                    err_q <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = (state == IDLE);
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
endmodule

// File: doc/store_serializer.md
# store_serializer

Store-path counterpart to the load-side sign/zero extension in the MIPS datapath. It accepts a byte, halfword or word store request from the memory stage and narrows it into a sequence of 8-bit writes on a byte-wide data-memory port, one byte per accepted beat, little-endian. Misaligned or reserved-size requests are rejected with an error pulse and cause no memory write. It sits between the MEM-stage controller and the byte-wide data RAM or bus.

## Interface
- ADDR_W, 32, byte-address width.
- DATA_W, 32, store data width. Fixed at 4 bytes; any other value is unsupported.
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  store request present.
- req_ready  out  1  block can accept a request; high only in IDLE.
- req_size  in  2  store size: 00 byte (sb), 01 half (sh), 10 word (sw), 11 reserved.
- req_addr  in  ADDR_W  byte address of the store.
- req_data  in  DATA_W  register data; the low 1, 2 or 4 bytes are stored.
- mem_we  out  1  byte write strobe to memory.
- mem_addr  out  ADDR_W  address of the current byte.
- mem_wdata  out  8  current data byte.
- mem_ready  in  1  memory accepts the byte when mem_we && mem_ready.
- done  out  1  one-cycle pulse: all bytes of the store were accepted.
- err  out  1  one-cycle pulse: request rejected (misaligned or reserved size).

## Operation
- Handshake: a request is accepted on a rising edge with req_valid && req_ready. The address, data and size are latched then. Inputs are don't-care at all other times.
- Byte count N: 1 for byte, 2 for half, 4 for word.
- Alignment check on acceptance:
  - half requires req_addr[0]==0;
  - word requires req_addr[1:0]==00;
  - size 11 is always an error.
- States:
  - IDLE: req_ready=1. On an aligned accept, load byte counter k=0 and go to WRITE. On an error accept, go to ERR.
  - WRITE: mem_we=1, mem_addr=addr+k, mem_wdata=data[8k+7:8k].
    - mem_ready=0: hold all three outputs stable and stay in WRITE.
    - mem_ready=1 with k<N-1: increment k.
    - mem_ready=1 with k==N-1: go to RESP.
  - RESP: done=1, mem_we=0, then IDLE.
  - ERR: err=1, mem_we=0, then IDLE.
- Address arithmetic is addr+k, modulo 2^ADDR_W. Wrap is impossible for legal aligned requests; it is specified anyway.
- Reset: state IDLE, k=0. Output values during and after reset:
  - req_ready=1 from the first cycle after reset;
  - mem_we=0, mem_addr=0, mem_wdata=0;
  - done=0, err=0.
- Reset mid-operation aborts the store. mem_we is low from the next cycle, no done or err pulse follows, and bytes already written stay written.
- req_valid during WRITE, RESP or ERR is ignored, because req_ready is low.

## Timing
- All outputs are registered or decoded from registered state only. There is no combinational input-to-output path except req_ready, which depends on state.
- Accept at edge 0. With mem_ready held high:
  - byte: mem_we in cycle 1; done in cycle 2; req_ready back in cycle 3.
  - half: bytes in cycles 1–2; done in cycle 3.
  - word: bytes in cycles 1–4; done in cycle 5.
- Each cycle with mem_ready=0 during WRITE adds one cycle of latency.
- Error: err in cycle 1; req_ready back in cycle 2.
- Peak throughput is one byte per cycle. There is a 2-cycle gap between stores (RESP and IDLE).

## Structure
- Shared package store_pkg holds:
  - store_size_e (SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10, SZ_RSVD=2'b11);
  - store_state_e (IDLE, WRITE, RESP, ERR);
  - function bytes_of(store_size_e) returning N.
- One sub-module, store_align_chk: combinational. Inputs size and addr[1:0]; outputs ok and nbytes. It is instantiated once in the IDLE accept path.
- Everything else (FSM, k counter, data/address registers, byte mux) is inside store_serializer.

## Test plan
- sw, addr 0x0000_1000, data 0xDEAD_BEEF, mem_ready=1. Required: writes (0x1000,0xEF), (0x1001,0xBE), (0x1002,0xAD), (0x1003,0xDE) in cycles 1–4; done in cycle 5.
- sh, addr 0x0000_0202, data 0x1234_5678, mem_ready toggling 1,0,1. Required: (0x0202,0x78) accepted; (0x0203,0x56) held stable through the stall, then accepted; one done; upper bytes never written.
- sb, addr 0x0000_0007, data 0xFFFF_FF80. Required: a single write (0x0007,0x80), done in cycle 2.
- Error cases: sh at addr 0x0000_0001, sw at 0x0000_0006, and size 11 at 0x0000_0000. Required for each: err in cycle 1, mem_we never asserted, req_ready high in cycle 2.
- rst asserted in cycle 2 of an sw, after byte 0 was accepted. Required: mem_we=0 from cycle 3, done and err never pulse, req_ready=1 after reset releases, and a following sb completes normally.
- Back-to-back: req_valid held high with two queued sb requests. Required: the second is accepted only when req_ready=1, i.e. 3 cycles after the first accept; exactly two done pulses.
